// File: rtl/forwarding_scoreboard.sv
// Hazard-detection and forwarding-control unit for an in-order MIPS pipeline.
// Tracks the destinations of the last DEPTH issued instructions (slot 1 = EXE ... slot DEPTH = WB).
module forwarding_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int SEL_W    = 2,
  parameter int ALU_RDY  = 2,
  parameter int LOAD_RDY = 3,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_load,
  input  logic              id_branch,
  input  logic              flush,
  input  logic              stall_ext,
  output logic              hazard_stall,
  output logic [SEL_W-1:0]  id_a_sel,
  output logic [SEL_W-1:0]  id_b_sel,
  output logic [SEL_W-1:0]  exe_a_sel,
  output logic [SEL_W-1:0]  exe_b_sel,
  output logic [CNT_W-1:0]  stall_count
);

  logic [DEPTH:1]    v_q, v_d;
  logic [DEPTH:1]    ld_q, ld_d;
  logic [REG_AW-1:0] dest_q [1:DEPTH];
  logic [REG_AW-1:0] dest_d [1:DEPTH];
  logic [SEL_W-1:0]  exe_a_sel_q, exe_a_sel_d;
  logic [SEL_W-1:0]  exe_b_sel_q, exe_b_sel_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic [DEPTH:1]    a_hit, b_hit;
  logic [SEL_W-1:0]  a_slot, b_slot;
  logic              a_ld, b_ld;
  logic              a_hz, b_hz;
  logic              issue;

  genvar gi;
  for (gi = 1; gi <= DEPTH; gi++) begin : g_match
    assign a_hit[gi] = v_q[gi] && (dest_q[gi] == id_rs) && id_rs_used;
    assign b_hit[gi] = v_q[gi] && (dest_q[gi] == id_rt) && id_rt_used;
  end

  function automatic logic ready_at(input int pos, input logic is_load);
    return pos >= (is_load ? LOAD_RDY : ALU_RDY);
  endfunction

  // Branches consume operands now; everything else needs them one slot later, in EXE.
  function automatic logic op_hazard(input logic [SEL_W-1:0] slot, input logic is_load,
                                     input logic branch);
    int k;
    k = int'(slot);
    if (k == 0) return 1'b0;
    if (branch) return !ready_at(k, is_load);
    return (k < DEPTH) && !ready_at(k + 1, is_load);
  endfunction

  function automatic logic [SEL_W-1:0] exe_fwd(input logic [SEL_W-1:0] slot);
    int k;
    k = int'(slot);
    return (k != 0 && k < DEPTH) ? SEL_W'(k + 1) : '0;
  endfunction

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    a_slot = '0;
    a_ld   = 1'b0;
    b_slot = '0;
    b_ld   = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (a_hit[k]) begin
        a_slot = SEL_W'(k);
        a_ld   = ld_q[k];
      end
      if (b_hit[k]) begin
        b_slot = SEL_W'(k);
        b_ld   = ld_q[k];
      end
    end
  end

  assign a_hz         = op_hazard(a_slot, a_ld, id_branch);
  assign b_hz         = op_hazard(b_slot, b_ld, id_branch);
  assign hazard_stall = id_valid && !flush && (a_hz || b_hz);
  assign issue        = id_valid && !flush && !hazard_stall;
  assign id_a_sel     = id_branch ? a_slot : '0;
  assign id_b_sel     = id_branch ? b_slot : '0;

  always_comb begin
    v_d           = v_q;
    ld_d          = ld_q;
    dest_d        = dest_q;
    exe_a_sel_d   = exe_a_sel_q;
    exe_b_sel_d   = exe_b_sel_q;
    stall_count_d = stall_count_q;
    if (!stall_ext) begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_d[k]    = v_q[k-1];
        ld_d[k]   = ld_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
      v_d[1]      = issue && id_reg_write && (id_dest != '0);
      ld_d[1]     = id_load;
      dest_d[1]   = id_dest;
      exe_a_sel_d = issue ? exe_fwd(a_slot) : '0;
      exe_b_sel_d = issue ? exe_fwd(b_slot) : '0;
      if (hazard_stall && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      v_q           <= '0;
      ld_q          <= '0;
      for (int k = 1; k <= DEPTH; k++) dest_q[k] <= '0;
      exe_a_sel_q   <= '0;
      exe_b_sel_q   <= '0;
      stall_count_q <= '0;
    end else begin
      v_q           <= v_d;
      ld_q          <= ld_d;
      dest_q        <= dest_d;
      exe_a_sel_q   <= exe_a_sel_d;
      exe_b_sel_q   <= exe_b_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign exe_a_sel   = exe_a_sel_q;
  assign exe_b_sel   = exe_b_sel_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: an age-list model checked every cycle,
// plus hand-computed literal expectations along the test plan.
module tb_forwarding_scoreboard;

  localparam int DEPTH     = 3;
  localparam int ALU_NEED  = 2;
  localparam int LOAD_NEED = 3;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        id_valid, id_rs_used, id_rt_used, id_reg_write, id_load, id_branch;
  logic        flush, stall_ext;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        hazard_stall;
  logic [1:0]  id_a_sel, id_b_sel, exe_a_sel, exe_b_sel;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v;
    int dest;
    bit ld;
  } ent_t;

  ent_t q[$];   // q[0] is the most recently issued (age 1)
  int   m_exe_a, m_exe_b, m_cnt;

  forwarding_scoreboard dut (
    .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_load(id_load),
    .id_branch(id_branch), .flush(flush), .stall_ext(stall_ext),
    .hazard_stall(hazard_stall), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .exe_a_sel(exe_a_sel), .exe_b_sel(exe_b_sel), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic youngest(input int r, input bit used, output int age, output bit ld);
    age = 0;
    ld  = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (used && q[i].v && q[i].dest == r) begin
        age = i + 1;
        ld  = q[i].ld;
      end
    end
  endtask

  function automatic bit operand_hazard(input int age, input bit ld, input bit br);
    int need;
    need = ld ? LOAD_NEED : ALU_NEED;
    if (age == 0) return 1'b0;
    if (br) return age < need;
    return (age < DEPTH) && (age + 1 < need);
  endfunction

  task automatic model_eval(output bit hz, output int ida, output int idb,
                            output int exa, output int exb);
    int  aa, ab;
    bit  la, lb;
    youngest(int'(id_rs), id_rs_used, aa, la);
    youngest(int'(id_rt), id_rt_used, ab, lb);
    hz  = id_valid && !flush && (operand_hazard(aa, la, id_branch) || operand_hazard(ab, lb, id_branch));
    ida = id_branch ? aa : 0;
    idb = id_branch ? ab : 0;
    exa = (aa != 0 && aa < DEPTH) ? aa + 1 : 0;
    exb = (ab != 0 && ab < DEPTH) ? ab + 1 : 0;
  endtask

  task automatic model_clear();
    q.delete();
    m_exe_a = 0;
    m_exe_b = 0;
    m_cnt   = 0;
  endtask

  task automatic compare_cycle();
    bit hz;
    int ida, idb, exa, exb;
    if (!RESET_N) model_clear();
    model_eval(hz, ida, idb, exa, exb);
    chk("cyc_hazard_stall", int'(hazard_stall), int'(hz));
    chk("cyc_id_a_sel", int'(id_a_sel), ida);
    chk("cyc_id_b_sel", int'(id_b_sel), idb);
    chk("cyc_exe_a_sel", int'(exe_a_sel), m_exe_a);
    chk("cyc_exe_b_sel", int'(exe_b_sel), m_exe_b);
    chk("cyc_stall_count", int'(stall_count), m_cnt);
  endtask

  task automatic model_edge();
    bit   hz, iss;
    int   ida, idb, exa, exb;
    ent_t e;
    if (!RESET_N) begin
      model_clear();
    end else if (!stall_ext) begin
      model_eval(hz, ida, idb, exa, exb);
      if (hz && m_cnt != 65535) m_cnt++;
      iss     = id_valid && !flush && !hz;
      m_exe_a = iss ? exa : 0;
      m_exe_b = iss ? exb : 0;
      e.v     = iss && id_reg_write && (id_dest != 5'd0);
      e.dest  = int'(id_dest);
      e.ld    = id_load;
      q.push_front(e);
      if (q.size() > DEPTH) void'(q.pop_back());
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input string tag, input bit v, input int rs, input bit rsu,
                       input int rt, input bit rtu, input int dest, input bit wr,
                       input bit ld, input bit br, input bit fl, input bit sx);
    id_valid     = v;
    id_rs        = 5'(rs);
    id_rs_used   = rsu;
    id_rt        = 5'(rt);
    id_rt_used   = rtu;
    id_dest      = 5'(dest);
    id_reg_write = wr;
    id_load      = ld;
    id_branch    = br;
    flush        = fl;
    stall_ext    = sx;
    $display("txn %-8s v=%0d rs=%0d rt=%0d dest=%0d wr=%0d ld=%0d br=%0d flush=%0d frz=%0d",
             tag, v, rs, rt, dest, wr, ld, br, fl, sx);
  endtask

  task automatic alu(input string tag, input int dest, input int rs, input int rt);
    drive(tag, 1, rs, 1, rt, 1, dest, 1, 0, 0, 0, 0);
  endtask

  task automatic lw(input string tag, input int dest);
    drive(tag, 1, 1, 1, 0, 0, dest, 1, 1, 0, 0, 0);
  endtask

  task automatic beq(input string tag, input int rs);
    drive(tag, 1, rs, 1, 0, 1, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic drain();
    drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH) tick();
  endtask

  initial begin
    RESET_N = 1'b1;
    drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 RESET_N = 1'b0;
    fork
      forever begin @(negedge CLK); compare_cycle(); end
      forever begin @(posedge CLK); model_edge(); end
    join_none

    // Reset state
    repeat (2) tick();
    chk("rst_hazard", int'(hazard_stall), 0);
    chk("rst_exe_a", int'(exe_a_sel), 0);
    chk("rst_exe_b", int'(exe_b_sel), 0);
    chk("rst_count", int'(stall_count), 0);
    RESET_N = 1'b1;
    tick();

    // Back-to-back ALU dependency
    alu("add3", 3, 1, 1); tick();
    alu("sub4", 4, 3, 5); #1 chk("alu_no_stall", int'(hazard_stall), 0);
    tick(); chk("alu_exe_a_2", int'(exe_a_sel), 2); chk("alu_exe_b_0", int'(exe_b_sel), 0);
    alu("or9", 9, 3, 0); tick(); chk("alu_exe_a_3", int'(exe_a_sel), 3);
    drain();

    // Load-use
    lw("lw6", 6); tick();
    alu("add7", 7, 6, 6); #1 chk("lu_stall", int'(hazard_stall), 1);
    tick(); chk("lu_count_1", int'(stall_count), 1);
    #1 chk("lu_stall_gone", int'(hazard_stall), 0);
    tick(); chk("lu_exe_a_3", int'(exe_a_sel), 3); chk("lu_exe_b_3", int'(exe_b_sel), 3);
    drain();

    // Branch on an ALU result
    alu("add2", 2, 1, 1); tick();
    beq("beq2a", 2); #1 chk("bra_stall", int'(hazard_stall), 1); chk("bra_id_a_1", int'(id_a_sel), 1);
    tick(); chk("bra_no_stall", int'(hazard_stall), 0); chk("bra_id_a_2", int'(id_a_sel), 2);
    tick(); drain();

    // Branch on a load result
    lw("lw2", 2); tick();
    beq("beq2l", 2); #1 chk("brl_stall1", int'(hazard_stall), 1);
    tick(); chk("brl_stall2", int'(hazard_stall), 1);
    tick(); chk("brl_no_stall", int'(hazard_stall), 0); chk("brl_id_a_3", int'(id_a_sel), 3);
    chk("brl_count_4", int'(stall_count), 4);
    tick(); drain();

    // Register 0 never matches; youngest writer wins
    alu("w0", 0, 1, 1); tick();
    alu("rd0", 10, 0, 0); #1 chk("r0_no_stall", int'(hazard_stall), 0);
    tick(); chk("r0_exe_a", int'(exe_a_sel), 0); chk("r0_exe_b", int'(exe_b_sel), 0);
    alu("w8a", 8, 1, 1); tick();
    alu("w8b", 8, 1, 1); tick();
    alu("rd8", 16, 8, 1); tick(); chk("prio_exe_a_2", int'(exe_a_sel), 2);
    drain();

    // Freeze holds slots and selects
    alu("w11", 11, 1, 1); tick();
    alu("r11", 12, 11, 1); tick(); chk("frz_pre_exe_a", int'(exe_a_sel), 2);
    drive("r11frz", 1, 11, 1, 1, 1, 13, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("frz_hold_exe_a", int'(exe_a_sel), 2); chk("frz_hold_exe_b", int'(exe_b_sel), 0);
    end
    drive("r11go", 1, 11, 1, 1, 1, 13, 1, 0, 0, 0, 0);
    tick(); chk("frz_after_exe_a_3", int'(exe_a_sel), 3);
    drain();

    // Freeze during a hazard: stall shown but not counted
    lw("lw13", 13); tick();
    drive("u13frz", 1, 13, 1, 1, 1, 14, 1, 0, 0, 0, 1); #1 chk("fh_stall", int'(hazard_stall), 1);
    repeat (2) tick();
    chk("fh_count_held", int'(stall_count), 4); chk("fh_still_stall", int'(hazard_stall), 1);
    drive("u13go", 1, 13, 1, 1, 1, 14, 1, 0, 0, 0, 0);
    tick(); chk("fh_count_5", int'(stall_count), 5);
    tick(); chk("fh_exe_a_3", int'(exe_a_sel), 3);
    drain();

    // Flush wins over a load-use hazard
    lw("lw14", 14); tick();
    drive("u14fl", 1, 14, 1, 1, 1, 17, 1, 0, 0, 1, 0); #1 chk("fl_no_stall", int'(hazard_stall), 0);
    tick(); chk("fl_bubble_exe_a", int'(exe_a_sel), 0); chk("fl_count_5", int'(stall_count), 5);
    alu("u14", 17, 14, 1); #1 chk("fl_next_no_stall", int'(hazard_stall), 0);
    tick(); chk("fl_next_exe_a_3", int'(exe_a_sel), 3);
    drain();

    // Reset in the middle of a stall
    lw("lw15", 15); tick();
    alu("u15", 18, 15, 1); #1 chk("rs_stall", int'(hazard_stall), 1);
    #1 RESET_N = 1'b0;
    #1;
    chk("rs_hazard_0", int'(hazard_stall), 0);
    chk("rs_id_a_0", int'(id_a_sel), 0);
    chk("rs_exe_a_0", int'(exe_a_sel), 0);
    chk("rs_exe_b_0", int'(exe_b_sel), 0);
    chk("rs_count_0", int'(stall_count), 0);
    tick(); RESET_N = 1'b1;
    #1 chk("rs_after_no_stall", int'(hazard_stall), 0);
    tick(); chk("rs_after_exe_a_0", int'(exe_a_sel), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
Parametrised hazard-detection and forwarding-control unit for the in-order MIPS pipeline.
- Tracks the destination registers of the last DEPTH issued instructions in a valid-tagged shift register (slot 1 = EXE, slot 2 = MEM, …).
- Produces registered operand-forward selects for EXE and combinational forward selects for branch/JR operands resolved in ID.
- Detects load-use and branch-operand hazards and inserts bubbles.
- Supports an external pipeline freeze and a saturating stall-cycle counter.

Parameters:
- DEPTH, 3: number of tracked in-flight producer slots (slot DEPTH = WB).
- REG_AW, 5: register-address width.
- SEL_W, 2: select width; must be ≥ clog2(DEPTH+1).
- ALU_RDY, 2: lowest slot from which a non-load result is forwardable.
- LOAD_RDY, 3: lowest slot from which a load result is forwardable; must be ≥ ALU_RDY and ≤ DEPTH.
- CNT_W, 16: stall-counter width.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source A register.
- id_rs_used  in  1  instruction reads rs.
- id_rt  in  REG_AW  source B register.
- id_rt_used  in  1  instruction reads rt.
- id_dest  in  REG_AW  destination register, already muxed for rd/rt/$31.
- id_reg_write  in  1  instruction writes id_dest.
- id_load  in  1  instruction is a load.
- id_branch  in  1  instruction consumes operands in ID (branch or JR).
- flush  in  1  kill the ID instruction.
- stall_ext  in  1  freeze the whole pipeline this cycle.
- hazard_stall  out  1  combinational; hold PC/IF/ID and insert a bubble.
- id_a_sel  out  SEL_W  combinational; ID-stage forward slot for rs (0 = register file).
- id_b_sel  out  SEL_W  combinational; ID-stage forward slot for rt.
- exe_a_sel  out  SEL_W  registered; EXE forward slot for rs (0 = register file).
- exe_b_sel  out  SEL_W  registered; EXE forward slot for rt.
- stall_count  out  CNT_W  registered; saturating count of hazard_stall cycles.

Behaviour:
Slot state
- Each slot k (1..DEPTH) holds {v, dest, ld}.
- v = 1 only when the producer is valid, id_reg_write = 1 and id_dest != 0. Register 0 never matches.

Matching
- match(r, k) = slot[k].v & slot[k].dest == r & used-flag for r.
- Youngest (lowest k) match wins.
- rdy(k) = k ≥ (slot[k].ld ? LOAD_RDY : ALU_RDY).

ID-stage selects (combinational)
- id_x_sel = k of the youngest match when id_branch = 1; otherwise 0.

Hazard stall (combinational)
- Branch hazard: id_branch and the youngest match k has !rdy(k).
- Non-branch hazard: youngest match k < DEPTH and slot k+1 will not be ready. Evaluate rdy at k+1 using slot[k].ld.
- A slot-DEPTH match is not a hazard; the register file is written at that edge and reads are write-first.
- hazard_stall = id_valid & !flush & (hazard on rs | hazard on rt).

Edge update when stall_ext = 0
- Shift slot[k+1] ← slot[k]; slot[DEPTH] is discarded.
- slot[1] ← ID entry if id_valid & !flush & !hazard_stall, otherwise a bubble (v = 0).
- On issue, exe_x_sel ← k+1 for the youngest match k < DEPTH, else 0.
- On bubble, exe_x_sel ← 0.

Freeze and counter
- When stall_ext = 1, all slots, exe selects and stall_count hold. hazard_stall is still computed.
- stall_count increments on each edge with hazard_stall = 1 & stall_ext = 0, and saturates at all-ones.

Reset
- Asynchronous, active-low: all v = 0, exe_a_sel = exe_b_sel = 0, stall_count = 0.
- With all slots invalid, the combinational outputs settle to 0.
- Reset mid-stall discards all in-flight entries.

Simultaneous events
- flush together with a hazard: flush wins; no stall, bubble inserted.
- stall_ext together with hazard_stall: no shift and no count.
- Both rs and rt hazards: a single stall.

Test Plan:
- Back-to-back ALU dependency: `add $3,…` then `sub $4,$3,$5` → no stall; the sub gets exe_a_sel = 2. A third instruction reading $3 gets exe_a_sel = 3.
- Load-use: `lw $6` then `add $7,$6,$6` → hazard_stall = 1 for one cycle and stall_count = 1. The add then gets exe_a_sel = exe_b_sel = 3.
- Branch on an ALU result: `add $2` then `beq $2,$0` → stall 1 cycle. Then id_a_sel = 2 and no stall.
- Branch on a load result: `lw $2` then `beq $2` → stall 2 cycles, then id_a_sel = 3.
- Register 0 and priority: `add $0` then a reader of $0 → all selects 0. Two writers of $8 at slots 1 and 2 → youngest wins, so exe sel = 2.
- Freeze, flush and reset: stall_ext held 3 cycles → slots and selects unchanged. Flush during a load-use hazard → no stall, bubble. RESET_N low mid-stall → all outputs 0 immediately.
